// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage (with package id_ex_pkg)
// Purpose  : ID/EX pipeline register for a 5-stage RV32 core. It registers
//            the decoded control and datapath values one cycle after decode,
//            detects load-use hazards against the instruction now in EX, and
//            inserts bubbles for hazards and for EX-stage redirects (flush).
//            A global hold freezes every register in the stage.
// Ports    : clk, rst_n (async assert, active-low)
//            id_*_i      decode-stage control/datapath values
//            flush_i     kill the decode-stage instruction (EX redirect)
//            hold_i      freeze the whole stage (memory wait)
//            ex_*_o      registered copies, ex_valid_o marks a real instruction
//            stall_id_o  combinational; freezes PC and the IF/ID register
//            stall_cnt_o, flush_cnt_o  bubble counters, only when the macro
//                        PERF_CNT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================

package id_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Everything the stage carries from ID to EX, as one register word.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    alu_op_t     alu_control;
    logic [1:0]  alu_src_a;
    logic [1:0]  mem_to_reg;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } ex_regs_t;

endpackage

module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic        id_reg_write_i,
  input  logic        id_alu_src_i,
  input  logic        id_mem_write_i,
  input  logic        id_branch_i,
  input  logic        id_jump_i,
  input  logic        id_jalr_i,
  input  alu_op_t     id_alu_control_i,
  input  logic [1:0]  id_alu_src_a_i,
  input  logic [1:0]  id_mem_to_reg_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic [2:0]  id_funct3_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        ex_valid_o,
  output logic        ex_reg_write_o,
  output logic        ex_alu_src_o,
  output logic        ex_mem_write_o,
  output logic        ex_branch_o,
  output logic        ex_jump_o,
  output logic        ex_jalr_o,
  output alu_op_t     ex_alu_control_o,
  output logic [1:0]  ex_alu_src_a_o,
  output logic [1:0]  ex_mem_to_reg_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [2:0]  ex_funct3_o,
  output logic        stall_id_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [1:0] c_wb_mem = 2'b01;

  // A bubble is a NOP: nothing enabled, ALU set to ADD, all data zero.
  localparam ex_regs_t c_bubble = '{
    valid: 1'b0, reg_write: 1'b0, alu_src: 1'b0, mem_write: 1'b0,
    branch: 1'b0, jump: 1'b0, jalr: 1'b0, alu_control: ALU_ADD,
    alu_src_a: 2'b00, mem_to_reg: 2'b00, pc: 32'd0, rs1_data: 32'd0,
    rs2_data: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    funct3: 3'd0
  };

  ex_regs_t r_ex;
  ex_regs_t w_id_pkt;
  ex_regs_t w_ex_next;
  logic     w_hazard;

  always_comb begin
    w_id_pkt = '{
      valid: id_valid_i, reg_write: id_reg_write_i, alu_src: id_alu_src_i,
      mem_write: id_mem_write_i, branch: id_branch_i, jump: id_jump_i,
      jalr: id_jalr_i, alu_control: id_alu_control_i,
      alu_src_a: id_alu_src_a_i, mem_to_reg: id_mem_to_reg_i, pc: id_pc_i,
      rs1_data: id_rs1_data_i, rs2_data: id_rs2_data_i, imm: id_imm_i,
      rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i, funct3: id_funct3_i
    };
    // An empty decode slot must not write anything or redirect the PC,
    // whatever stale values the decoder leaves on its control bits.
    if (!id_valid_i) begin
      w_id_pkt.reg_write = 1'b0;
      w_id_pkt.mem_write = 1'b0;
      w_id_pkt.branch    = 1'b0;
      w_id_pkt.jump      = 1'b0;
      w_id_pkt.jalr      = 1'b0;
    end
  end

  // rs2 is compared for every opcode: a spurious stall on an I-type is
  // cheaper than decoding which instructions really read rs2.
  assign w_hazard = r_ex.valid && (r_ex.mem_to_reg == c_wb_mem) &&
                    (r_ex.rd != 5'd0) && id_valid_i &&
                    ((r_ex.rd == id_rs1_i) || (r_ex.rd == id_rs2_i));

  // A flushed or frozen decode slot must not freeze fetch on top of that.
  assign stall_id_o = w_hazard && !flush_i && !hold_i;

  always_comb begin
    w_ex_next = w_id_pkt;
    if (hold_i) begin
      w_ex_next = r_ex;
    end else if (flush_i || w_hazard) begin
      w_ex_next = c_bubble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= c_bubble;
    end else begin
      r_ex <= w_ex_next;
    end
  end

  assign ex_valid_o       = r_ex.valid;
  assign ex_reg_write_o   = r_ex.reg_write;
  assign ex_alu_src_o     = r_ex.alu_src;
  assign ex_mem_write_o   = r_ex.mem_write;
  assign ex_branch_o      = r_ex.branch;
  assign ex_jump_o        = r_ex.jump;
  assign ex_jalr_o        = r_ex.jalr;
  assign ex_alu_control_o = r_ex.alu_control;
  assign ex_alu_src_a_o   = r_ex.alu_src_a;
  assign ex_mem_to_reg_o  = r_ex.mem_to_reg;
  assign ex_pc_o          = r_ex.pc;
  assign ex_rs1_data_o    = r_ex.rs1_data;
  assign ex_rs2_data_o    = r_ex.rs2_data;
  assign ex_imm_o         = r_ex.imm;
  assign ex_rs1_o         = r_ex.rs1;
  assign ex_rs2_o         = r_ex.rs2;
  assign ex_rd_o          = r_ex.rd;
  assign ex_funct3_o      = r_ex.funct3;

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Counters wrap naturally at 32 bits; hold suppresses both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (!hold_i) begin
      if (flush_i) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else if (w_hazard) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire
